mul_unit_scheduler: RTL and testbench

//  Shares NUM_MUL multi-cycle shift-add multiplier units among NUM_RS multiply reservation-station entries.
//  - Grants one ready RS entry per cycle to a free unit (round-robin over RS).
//  - Sequences each unit's start/done handshake.
//  - Arbitrates finished units onto the single CDB port (round-robin over units).

---
 rtl/mul_unit_scheduler_if.sv | 44 ++++
 rtl/mul_unit_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_mul_unit_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_scheduler_if.sv
// ---------------------------------------------------------------------------
// mul_unit_scheduler_if
// Bundles the signals that connect the multiply scheduler to the reservation
// station, the multiplier units and the CDB port.
//   rs_req    : RS entries with operands ready (RS -> scheduler)
//   rs_grant  : one-hot grant back to the RS, combinational
//   mul_load  : one-hot "latch payload" strobe per unit, combinational
//   mul_src   : per-unit RS index, valid with mul_load[u]
//   mul_start : registered start level per unit
//   mul_done  : done level from each unit
//   cdb_valid : a finished unit is offered to the CDB
//   cdb_sel   : which unit is offered
//   cdb_ready : CDB accepts the offer this cycle
//   mul_busy  : unit is not FREE
// Modports: master = scheduler side, slave = environment side.
// ---------------------------------------------------------------------------
interface mul_unit_scheduler_if #(
    parameter int NUM_RS  = 4,
    parameter int NUM_MUL = 2
);
    localparam int RS_IDX_W  = $clog2(NUM_RS);
    localparam int MUL_IDX_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

    logic [NUM_RS-1:0]           rs_req;
    logic [NUM_RS-1:0]           rs_grant;
    logic [NUM_MUL-1:0]          mul_load;
    logic [NUM_MUL*RS_IDX_W-1:0] mul_src;
    logic [NUM_MUL-1:0]          mul_start;
    logic [NUM_MUL-1:0]          mul_done;
    logic                        cdb_valid;
    logic [MUL_IDX_W-1:0]        cdb_sel;
    logic                        cdb_ready;
    logic [NUM_MUL-1:0]          mul_busy;

    modport master (
        input  rs_req, mul_done, cdb_ready,
        output rs_grant, mul_load, mul_src, mul_start, cdb_valid, cdb_sel, mul_busy
    );

    modport slave (
        output rs_req, mul_done, cdb_ready,
        input  rs_grant, mul_load, mul_src, mul_start, cdb_valid, cdb_sel, mul_busy
    );
endinterface

// File: rtl/mul_unit_scheduler.sv
// ---------------------------------------------------------------------------
// mul_unit_scheduler
// Shares NUM_MUL multi-cycle multiplier units among NUM_RS multiply RS
// entries. Each cycle at most one ready RS entry (round-robin from rr_rs) is
// granted to the lowest-index FREE unit. Each unit runs a
// FREE -> BUSY -> RESULT -> DRAIN sequence, and finished units are offered to
// the single CDB port round-robin from rr_cdb.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (master)      : RS request/grant, unit load/src/start/done,
//                       CDB valid/sel/ready and per-unit busy
// Optional feature (macro MUL_SCHED_STATS_EN):
//   stat_busy_cycles  : cycles with every unit busy while some RS entry waits
//   stat_cdb_stall    : cycles with a CDB offer that is not accepted
// ---------------------------------------------------------------------------
module mul_unit_scheduler #(
    parameter int NUM_RS  = 4,
    parameter int NUM_MUL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_unit_scheduler_if.master bus
`ifdef MUL_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_busy_cycles,
    output logic [31:0]          stat_cdb_stall
`endif
);
    localparam int RS_IDX_W  = $clog2(NUM_RS);
    localparam int MUL_IDX_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2,
        ST_DRAIN  = 2'd3
    } unit_state_e;

    unit_state_e          state_q [NUM_MUL];
    unit_state_e          state_d [NUM_MUL];
    logic [NUM_MUL-1:0]   start_q, start_d;
    logic [NUM_MUL-1:0]   busy_q, busy_d;
    logic [RS_IDX_W-1:0]  rr_rs_q, rr_rs_d;
    logic [MUL_IDX_W-1:0] rr_cdb_q, rr_cdb_d;
    logic [MUL_IDX_W-1:0] cdb_sel_q, cdb_sel_d;
    logic                 cdb_valid_q, cdb_valid_d;

    logic                 free_found, req_found, issue, cdb_xfer;
    logic [MUL_IDX_W-1:0] free_idx, cdb_cand;
    logic [RS_IDX_W-1:0]  req_idx, rs_cand;

    // Issue selection: lowest FREE unit, first request at or after rr_rs.
    // Only units FREE in the registered state count, so a unit leaving DRAIN
    // this cycle cannot be granted until the next one.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int u = 0; u < NUM_MUL; u++) begin
            if (!free_found && state_q[u] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = MUL_IDX_W'(u);
            end
        end
        req_found = 1'b0;
        req_idx   = '0;
        rs_cand   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            rs_cand = rr_rs_q + RS_IDX_W'(k);   // NUM_RS is a power of 2: wraps naturally
            if (!req_found && bus.rs_req[rs_cand]) begin
                req_found = 1'b1;
                req_idx   = rs_cand;
            end
        end
        issue = free_found && req_found;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_grant
            assign bus.rs_grant[gi] = issue && (req_idx == RS_IDX_W'(gi));
        end
        for (gi = 0; gi < NUM_MUL; gi++) begin : g_load
            assign bus.mul_load[gi] = issue && (free_idx == MUL_IDX_W'(gi));
            assign bus.mul_src[gi*RS_IDX_W +: RS_IDX_W] =
                (issue && (free_idx == MUL_IDX_W'(gi))) ? req_idx : '0;
        end
    endgenerate

    assign cdb_xfer = cdb_valid_q && bus.cdb_ready;

    // Per-unit sequencing. mul_done is only meaningful in BUSY (completion)
    // and DRAIN (wait for the unit to drop it); elsewhere it is ignored.
    always_comb begin
        start_d = '0;
        busy_d  = '0;
        for (int u = 0; u < NUM_MUL; u++) begin
            state_d[u] = state_q[u];
            case (state_q[u])
                ST_FREE:   if (issue && free_idx == MUL_IDX_W'(u))              state_d[u] = ST_BUSY;
                ST_BUSY:   if (bus.mul_done[u])                                 state_d[u] = ST_RESULT;
                ST_RESULT: if (cdb_xfer && cdb_sel_q == MUL_IDX_W'(u))          state_d[u] = ST_DRAIN;
                ST_DRAIN:  if (!bus.mul_done[u])                                state_d[u] = ST_FREE;
                default:                                                        state_d[u] = ST_FREE;
            endcase
            // start stays high through RESULT so the unit keeps holding its product
            start_d[u] = (state_d[u] == ST_BUSY) || (state_d[u] == ST_RESULT);
            busy_d[u]  = (state_d[u] != ST_FREE);
        end
    end

    assign rr_rs_d = issue ? (req_idx + 1'b1) : rr_rs_q;

    // CDB offer is registered. While an offer is pending and not accepted it
    // is frozen; otherwise the next offer is picked from the next-state view.
    always_comb begin
        rr_cdb_d = rr_cdb_q;
        if (cdb_xfer) begin
            rr_cdb_d = (NUM_MUL == 1) ? '0 : (cdb_sel_q + 1'b1);
        end
        cdb_valid_d = 1'b0;
        cdb_sel_d   = cdb_sel_q;
        cdb_cand    = '0;
        if (cdb_valid_q && !bus.cdb_ready) begin
            cdb_valid_d = 1'b1;
        end else begin
            for (int k = 0; k < NUM_MUL; k++) begin
                cdb_cand = (NUM_MUL == 1) ? '0 : (rr_cdb_d + MUL_IDX_W'(k));
                if (!cdb_valid_d && state_d[cdb_cand] == ST_RESULT) begin
                    cdb_valid_d = 1'b1;
                    cdb_sel_d   = cdb_cand;
                end
            end
        end
    end

`ifdef MUL_SCHED_STATS_EN
    logic [31:0] stat_busy_q, stat_busy_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_busy_d  = stat_busy_q  + (((&busy_q) && (|bus.rs_req)) ? 32'd1 : 32'd0);
        stat_stall_d = stat_stall_q + ((cdb_valid_q && !bus.cdb_ready) ? 32'd1 : 32'd0);
    end

    assign stat_busy_cycles = stat_busy_q;
    assign stat_cdb_stall   = stat_stall_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int u = 0; u < NUM_MUL; u++) state_q[u] <= ST_FREE;
            start_q     <= '0;
            busy_q      <= '0;
            rr_rs_q     <= '0;
            rr_cdb_q    <= '0;
            cdb_sel_q   <= '0;
            cdb_valid_q <= 1'b0;
`ifdef MUL_SCHED_STATS_EN
            stat_busy_q  <= '0;
            stat_stall_q <= '0;
`endif
        end else begin
            for (int u = 0; u < NUM_MUL; u++) state_q[u] <= state_d[u];
            start_q     <= start_d;
            busy_q      <= busy_d;
            rr_rs_q     <= rr_rs_d;
            rr_cdb_q    <= rr_cdb_d;
            cdb_sel_q   <= cdb_sel_d;
            cdb_valid_q <= cdb_valid_d;
`ifdef MUL_SCHED_STATS_EN
            stat_busy_q  <= stat_busy_d;
            stat_stall_q <= stat_stall_d;
`endif
        end
    end

    assign bus.mul_start = start_q;
    assign bus.mul_busy  = busy_q;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_sel   = cdb_sel_q;

endmodule

// File: tb/tb_mul_unit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mul_unit_scheduler
// Drives directed and random RS requests, unit done levels and CDB ready.
// A reference model tracks each unit as "owner RS index / result held /
// handed to CDB" and predicts every output; predictions go into a queue and a
// negedge monitor pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_mul_unit_scheduler;
    localparam int NUM_RS  = 4;
    localparam int NUM_MUL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_unit_scheduler_if #(.NUM_RS(NUM_RS), .NUM_MUL(NUM_MUL)) bus ();

`ifdef MUL_SCHED_STATS_EN
    logic [31:0] stat_busy_cycles, stat_cdb_stall;
`endif

    mul_unit_scheduler #(.NUM_RS(NUM_RS), .NUM_MUL(NUM_MUL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MUL_SCHED_STATS_EN
        ,
        .stat_busy_cycles (stat_busy_cycles),
        .stat_cdb_stall   (stat_cdb_stall)
`endif
    );

    typedef struct {
        int          cyc;
        logic [3:0]  grant;
        logic [1:0]  load;
        logic [3:0]  src;
        logic [1:0]  start;
        logic [1:0]  busy;
        logic        valid;
        logic [0:0]  sel;
        logic [31:0] sbusy;
        logic [31:0] sstall;
    } exp_t;

    exp_t sb_q[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model state
    int          owner   [NUM_MUL];   // RS index held by the unit, -1 when free
    bit          has_res [NUM_MUL];   // unit has produced its product
    bit          xfered  [NUM_MUL];   // product already taken by the CDB
    int          rr_rs_m, rr_cdb_m, offer_m;
    logic [31:0] cnt_busy, cnt_stall;

    task automatic model_reset();
        for (int u = 0; u < NUM_MUL; u++) begin
            owner[u] = -1; has_res[u] = 1'b0; xfered[u] = 1'b0;
        end
        rr_rs_m = 0; rr_cdb_m = 0; offer_m = -1;
        cnt_busy = '0; cnt_stall = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, predict outputs, advance the model.
    task automatic step(input logic r, input logic [3:0] req, input logic rdy, input logic [1:0] done);
        exp_t e;
        int gu, gs, idx;
        bit all_busy;
        int n_owner [NUM_MUL];
        bit n_res   [NUM_MUL];
        bit n_x     [NUM_MUL];
        @(posedge clk);
        #1;
        cyc++;
        rst           = r;
        bus.rs_req    = req;
        bus.cdb_ready = rdy;
        bus.mul_done  = done;

        gu = -1;
        for (int u = 0; u < NUM_MUL; u++) if (gu < 0 && owner[u] < 0) gu = u;
        gs = -1;
        for (int k = 0; k < NUM_RS; k++) begin
            idx = (rr_rs_m + k) % NUM_RS;
            if (gs < 0 && req[idx]) gs = idx;
        end
        e.cyc = cyc; e.grant = '0; e.load = '0; e.src = '0;
        if (gu >= 0 && gs >= 0) begin
            e.grant[gs] = 1'b1;
            e.load[gu]  = 1'b1;
            e.src[gu*2 +: 2] = gs[1:0];
            $display("cycle %0d: grant rs%0d -> unit%0d", cyc, gs, gu);
        end
        all_busy = 1'b1;
        for (int u = 0; u < NUM_MUL; u++) begin
            e.start[u] = (owner[u] >= 0) && !xfered[u];
            e.busy[u]  = (owner[u] >= 0);
            if (owner[u] < 0) all_busy = 1'b0;
        end
        e.valid  = (offer_m >= 0);
        e.sel    = (offer_m >= 0) ? 1'(offer_m) : 1'b0;
        e.sbusy  = cnt_busy;
        e.sstall = cnt_stall;
        sb_q.push_back(e);
        if (offer_m >= 0 && rdy) $display("cycle %0d: cdb transfer unit%0d", cyc, offer_m);

        if (r) begin
            model_reset();
        end else begin
            if (all_busy && req != 0) cnt_busy = cnt_busy + 1;
            if (offer_m >= 0 && !rdy) cnt_stall = cnt_stall + 1;
            for (int u = 0; u < NUM_MUL; u++) begin
                n_owner[u] = owner[u]; n_res[u] = has_res[u]; n_x[u] = xfered[u];
                if (owner[u] >= 0 && xfered[u] && !done[u]) begin
                    n_owner[u] = -1; n_res[u] = 1'b0; n_x[u] = 1'b0;
                end else if (owner[u] >= 0 && !has_res[u] && done[u]) begin
                    n_res[u] = 1'b1;
                end
            end
            if (offer_m >= 0 && rdy) begin
                n_x[offer_m] = 1'b1;
                rr_cdb_m = (offer_m + 1) % NUM_MUL;
            end
            if (gu >= 0 && gs >= 0) begin
                n_owner[gu] = gs;
                rr_rs_m = (gs + 1) % NUM_RS;
            end
            for (int u = 0; u < NUM_MUL; u++) begin
                owner[u] = n_owner[u]; has_res[u] = n_res[u]; xfered[u] = n_x[u];
            end
            if (!(offer_m >= 0 && !rdy)) begin
                offer_m = -1;
                for (int k = 0; k < NUM_MUL; k++) begin
                    idx = (rr_cdb_m + k) % NUM_MUL;
                    if (offer_m < 0 && has_res[idx] && !xfered[idx]) offer_m = idx;
                end
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rs_grant",  32'(bus.rs_grant),  32'(e.grant), e.cyc);
            chk("mul_load",  32'(bus.mul_load),  32'(e.load),  e.cyc);
            chk("mul_src",   32'(bus.mul_src),   32'(e.src),   e.cyc);
            chk("mul_start", 32'(bus.mul_start), 32'(e.start), e.cyc);
            chk("mul_busy",  32'(bus.mul_busy),  32'(e.busy),  e.cyc);
            chk("cdb_valid", 32'(bus.cdb_valid), 32'(e.valid), e.cyc);
            if (e.valid) chk("cdb_sel", 32'(bus.cdb_sel), 32'(e.sel), e.cyc);
`ifdef MUL_SCHED_STATS_EN
            chk("stat_busy_cycles", stat_busy_cycles, e.sbusy,  e.cyc);
            chk("stat_cdb_stall",   stat_cdb_stall,   e.sstall, e.cyc);
`endif
        end
    end

    initial begin
        logic [1:0] done_r;
        logic [3:0] req_r;
        rst = 1'b1;
        bus.rs_req = '0; bus.cdb_ready = 1'b0; bus.mul_done = '0;
        model_reset();

        // Single request into idle units, then start observed.
        step(1, 4'b0000, 0, 2'b00);
        step(0, 4'b0001, 0, 2'b00);
        step(0, 4'b0000, 0, 2'b00);
        step(0, 4'b0000, 0, 2'b00);

        // All entries requesting: two grants, then all-busy cycles.
        step(1, 4'b0000, 0, 2'b00);
        for (int i = 0; i < 5; i++) step(0, 4'b1111, 0, 2'b00);
        // Both units finish together, CDB always ready.
        step(0, 4'b0000, 1, 2'b11);
        step(0, 4'b0000, 1, 2'b11);
        for (int i = 0; i < 4; i++) step(0, 4'b0000, 1, 2'b00);

        // Unit1 result stalled on the CDB for 5 cycles.
        step(1, 4'b0000, 0, 2'b00);
        step(0, 4'b0010, 0, 2'b00);
        step(0, 4'b0001, 0, 2'b00);
        step(0, 4'b0000, 0, 2'b10);
        for (int i = 0; i < 5; i++) step(0, 4'b0000, 0, 2'b00);
        step(0, 4'b0000, 1, 2'b00);
        step(0, 4'b0000, 1, 2'b00);
        step(0, 4'b0000, 1, 2'b00);

        // Reset while unit0 is busy.
        step(1, 4'b0000, 0, 2'b00);
        step(0, 4'b0001, 0, 2'b00);
        step(0, 4'b0000, 0, 2'b00);
        step(1, 4'b0000, 0, 2'b00);
        step(0, 4'b0000, 0, 2'b00);
        step(0, 4'b0000, 0, 2'b00);

        // Random traffic, including spurious done and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            for (int u = 0; u < NUM_MUL; u++) begin
                if (owner[u] < 0)              done_r[u] = ($urandom_range(0, 9) == 0);
                else if (!has_res[u])          done_r[u] = ($urandom_range(0, 2) == 0);
                else                           done_r[u] = ($urandom_range(0, 1) == 0);
            end
            req_r = (i % 2 == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            step(($urandom_range(0, 399) == 0), req_r, ($urandom_range(0, 99) < 60), done_r);
        end

        @(negedge clk);
        #1;
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
